// File: rtl/clk_divider_prog.sv
// Runtime-programmable clock divider.
//
// Produces a divided waveform (clk_out) and a one-cycle period-start strobe (tick) from clk.
// A new divisor is captured into a shadow register by div_load and only becomes active at a
// period boundary (wrap edge) or on any disabled edge, so a period is never cut short or
// stretched mid-way.
//
// Ports:
//   clk      - system clock, all logic on the rising edge
//   rst      - synchronous, active-high reset
//   en       - run enable; when low the outputs are held low and the counter is parked
//   div_in   - new divisor value
//   div_load - one-cycle strobe capturing clamp(div_in) into the shadow register
//   clk_out  - divided waveform, high for the first floor(D/2) cycles of each period
//   tick     - one-cycle pulse on the first cycle of each period
//   div_pend - a loaded divisor is waiting for the next apply edge
//   div_cur  - divisor currently in effect
module clk_divider_prog #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 300_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             div_pend,
  output logic [WIDTH-1:0] div_cur
);

  localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MinDiv = WIDTH'(2);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic wrap;
  logic apply;

  always_comb begin
    wrap  = (cnt_q == div_q - One);
    // The pending divisor is applied at a wrap edge or on any disabled edge.
    apply = pend_q && (!en || wrap);

    div_d = apply ? shadow_q : div_q;

    // Divisors below 2 cannot produce a valid waveform, so they are clamped on capture.
    shadow_d = shadow_q;
    if (div_load) begin
      shadow_d = (div_in < MinDiv) ? MinDiv : div_in;
    end

    // A load on an apply edge re-arms pend for the value just captured.
    pend_d = pend_q;
    if (div_load) begin
      pend_d = 1'b1;
    end else if (apply) begin
      pend_d = 1'b0;
    end

    if (en) begin
      cnt_d     = wrap ? '0 : cnt_q + One;
      clk_out_d = (cnt_d < (div_d >> 1));
      tick_d    = (cnt_d == '0);
    end else begin
      // Park on the last count so the first enabled edge starts a fresh period.
      cnt_d     = div_d - One;
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= DefDiv;
      cnt_q     <= DefDiv - One;
      shadow_q  <= DefDiv;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign div_pend = pend_q;
  assign div_cur  = div_q;

endmodule
